// File: rtl/text_console_pkg.sv
// Shared constants and state encoding for the text console write-port sequencer.
package text_console_pkg;

  localparam int COLS_DEFAULT = 80;
  localparam int ROWS_DEFAULT = 60;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/text_cursor.sv
// Cursor position (col, row) plus its linear cell address, kept in step without a multiplier.
module text_cursor
  import text_console_pkg::*;
#(
  parameter int COLS       = COLS_DEFAULT,
  parameter int ROWS       = ROWS_DEFAULT,
  parameter int ADDR_WIDTH = $clog2(COLS * ROWS),
  parameter int COL_W      = $clog2(COLS),
  parameter int ROW_W      = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_advance,
  input  logic                  op_back,
  input  logic                  op_cr,
  input  logic                  op_lf,
  input  logic                  op_home,
  output logic [COL_W-1:0]      col,
  output logic [ROW_W-1:0]      row,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_BASE = ADDR_WIDTH'((ROWS - 1) * COLS);

  // The ops are one-hot; the linear address moves by +1, -1, +COLS or -col alongside col/row.
  always_ff @(posedge clk) begin
    if (rst || op_home) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (op_advance) begin
      if (col == LAST_COL) begin
        col <= '0;
        if (row == LAST_ROW) begin
          row  <= '0;
          addr <= '0;
        end else begin
          row  <= row + ROW_W'(1);
          addr <= addr + ADDR_WIDTH'(1);
        end
      end else begin
        col  <= col + COL_W'(1);
        addr <= addr + ADDR_WIDTH'(1);
      end
    end else if (op_back) begin
      if (col != '0) begin
        col  <= col - COL_W'(1);
        addr <= addr - ADDR_WIDTH'(1);
      end
    end else if (op_cr) begin
      col  <= '0;
      addr <= addr - ADDR_WIDTH'(col);
    end else if (op_lf) begin
      if (row == LAST_ROW) begin
        row  <= '0;
        addr <= addr - LAST_BASE;
      end else begin
        row  <= row + ROW_W'(1);
        addr <= addr + ROW_STEP;
      end
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Drives the text-buffer RAM write port from a byte stream: printable characters,
// CR/LF/BS/FF handling, and a full-screen blanking sweep after reset or on command.
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int               COLS       = COLS_DEFAULT,
  parameter int               ROWS       = ROWS_DEFAULT,
  parameter int               DATA_WIDTH = 8,
  parameter int               ADDR_WIDTH = $clog2(COLS * ROWS),
  parameter logic [DATA_WIDTH-1:0] BLANK = DATA_WIDTH'(8'h20)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     cmd_clear,
  output logic                     busy,
  output logic                     write_en,
  output logic [ADDR_WIDTH-1:0]    waddr,
  output logic [DATA_WIDTH-1:0]    din,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  cursor_row
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLS * ROWS - 1);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_n;
  logic                    write_en_n, busy_n;
  logic [ADDR_WIDTH-1:0]   waddr_n;
  logic [DATA_WIDTH-1:0]   din_n;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    op_advance, op_back, op_cr, op_lf, op_home;
  logic                    accept;

  assign in_ready = !rst && (state == ST_IDLE) && !cmd_clear;
  assign accept   = in_valid && in_ready;

  text_cursor #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .op_advance (op_advance),
    .op_back    (op_back),
    .op_cr      (op_cr),
    .op_lf      (op_lf),
    .op_home    (op_home),
    .col        (cursor_col),
    .row        (cursor_row),
    .addr       (cur_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_cnt  <= '0;
      write_en <= 1'b0;
      waddr    <= '0;
      din      <= '0;
      busy     <= 1'b1;
    end else begin
      state    <= state_n;
      clr_cnt  <= clr_cnt_n;
      write_en <= write_en_n;
      waddr    <= waddr_n;
      din      <= din_n;
      busy     <= busy_n;
    end
  end

  // busy is registered so it stays high through the cycle showing the last blank write.
  always_comb begin
    state_n    = state;
    clr_cnt_n  = clr_cnt;
    write_en_n = 1'b0;
    waddr_n    = waddr;
    din_n      = din;
    busy_n     = busy;
    op_advance = 1'b0;
    op_back    = 1'b0;
    op_cr      = 1'b0;
    op_lf      = 1'b0;
    op_home    = 1'b0;

    case (state)
      ST_CLEAR: begin
        write_en_n = 1'b1;
        waddr_n    = clr_cnt;
        din_n      = BLANK;
        busy_n     = 1'b1;
        if (clr_cnt == LAST_CELL) begin
          state_n   = ST_IDLE;
          clr_cnt_n = '0;
          op_home   = 1'b1;
        end else begin
          clr_cnt_n = clr_cnt + ADDR_WIDTH'(1);
        end
      end

      default: begin
        busy_n = 1'b0;
        if (cmd_clear) begin
          state_n   = ST_CLEAR;
          clr_cnt_n = '0;
          busy_n    = 1'b1;
        end else if (accept) begin
          if (in_data >= CH_SPACE) begin
            write_en_n = 1'b1;
            waddr_n    = cur_addr;
            din_n      = DATA_WIDTH'(in_data);
            op_advance = 1'b1;
          end else if (in_data == CH_CR) begin
            op_cr = 1'b1;
          end else if (in_data == CH_LF) begin
            op_lf = 1'b1;
          end else if (in_data == CH_BS) begin
            if (cursor_col != '0) begin
              write_en_n = 1'b1;
              waddr_n    = cur_addr - ADDR_WIDTH'(1);
              din_n      = BLANK;
              op_back    = 1'b1;
            end
          end else if (in_data == CH_FF) begin
            state_n   = ST_CLEAR;
            clr_cnt_n = '0;
            busy_n    = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: directed scenarios plus a randomized byte
// stream scored against a cell/cursor reference model.
module tb_text_console_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        cmd_clear = 1'b0;
  logic        in_ready, busy, write_en;
  logic [12:0] waddr;
  logic [7:0]  din;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_col  = 0;
  int m_row  = 0;

  bit obs_ready, obs_we;
  int obs_addr, obs_din, obs_col, obs_row;
  bit exp_we;
  int exp_addr, exp_din;

  text_console_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cmd_clear  (cmd_clear),
    .busy       (busy),
    .write_en   (write_en),
    .waddr      (waddr),
    .din        (din),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  // Reference model: cursor as plain integers, cell address by multiplication.
  function automatic void model_step(input logic [7:0] b, output bit we, output int addr, output int d);
    we = 1'b0; addr = 0; d = 0;
    if (b >= 8'h20) begin
      we = 1'b1; addr = m_row * COLS + m_col; d = b;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        we = 1'b1; addr = m_row * COLS + m_col; d = 8'h20;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    #1 obs_ready = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    obs_we   = write_en;
    obs_addr = waddr;
    obs_din  = din;
    obs_col  = cursor_col;
    obs_row  = cursor_row;
  endtask

  task automatic drive_model(input logic [7:0] b);
    model_step(b, exp_we, exp_addr, exp_din);
    send_byte(b);
  endtask

  task automatic goto_cell(input int c, input int r);
    drive_model(8'h0D);
    while (m_row != r) drive_model(8'h0A);
    repeat (c) drive_model(8'h2E);
  endtask

  // Follows a blanking sweep; stops on the first cycle without a write or after 'limit' writes.
  task automatic drain_clear(input int limit, output int n, output bit addr_ok, output bit busy_ok);
    n = 0; addr_ok = 1'b1; busy_ok = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      if (!write_en) break;
      if (waddr !== 13'(n) || din !== 8'h20) addr_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      n++;
      if (n == limit) break;
    end
  endtask

  task automatic test_reset;
    int n; bit aok, bok;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({write_en, busy, in_ready} !== 3'b010) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 010", {write_en, busy, in_ready}); end
    n_cmp++; if (waddr !== 13'd0 || din !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_port: got waddr=%0d din=%0h expected 0/0", waddr, din); end
    n_cmp++; if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_cursor: got (%0d,%0d) expected (0,0)", cursor_col, cursor_row); end
    rst = 1'b0;
    drain_clear(0, n, aok, bok);
    n_cmp++; if (n != CELLS) begin n_fail++; $display("[TB] FAIL clear_count: got %0d expected %0d", n, CELLS); end
    n_cmp++; if (!aok) begin n_fail++; $display("[TB] FAIL clear_sequence: got out-of-order/non-blank expected 0..4799 of 20"); end
    n_cmp++; if (!bok) begin n_fail++; $display("[TB] FAIL clear_busy: got busy low during sweep expected 1"); end
    n_cmp++; if ({busy, in_ready, write_en} !== 3'b010) begin n_fail++; $display("[TB] FAIL clear_done: got busy,ready,we=%b expected 010", {busy, in_ready, write_en}); end
    n_cmp++; if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin n_fail++; $display("[TB] FAIL clear_cursor: got (%0d,%0d) expected (0,0)", cursor_col, cursor_row); end
    m_col = 0; m_row = 0;
  endtask

  task automatic test_ab;
    drive_model(8'h41);
    n_cmp++; if (!obs_we || obs_addr != 0 || obs_din != 8'h41) begin n_fail++; $display("[TB] FAIL ab_first: got we=%0d addr=%0d din=%0h expected 1/0/41", obs_we, obs_addr, obs_din); end
    drive_model(8'h42);
    n_cmp++; if (!obs_we || obs_addr != 1 || obs_din != 8'h42) begin n_fail++; $display("[TB] FAIL ab_second: got we=%0d addr=%0d din=%0h expected 1/1/42", obs_we, obs_addr, obs_din); end
    @(posedge clk); #1;
    n_cmp++; if (write_en !== 1'b0 || cursor_col !== 7'd2 || cursor_row !== 6'd0) begin n_fail++; $display("[TB] FAIL ab_after: got we=%0d (%0d,%0d) expected 0 (2,0)", write_en, cursor_col, cursor_row); end
  endtask

  task automatic test_wrap;
    goto_cell(79, 59);
    drive_model(8'h58);
    n_cmp++; if (!obs_we || obs_addr != 4799 || obs_din != 8'h58) begin n_fail++; $display("[TB] FAIL wrap_write: got we=%0d addr=%0d din=%0h expected 1/4799/58", obs_we, obs_addr, obs_din); end
    n_cmp++; if (obs_col != 0 || obs_row != 0) begin n_fail++; $display("[TB] FAIL wrap_cursor: got (%0d,%0d) expected (0,0)", obs_col, obs_row); end
  endtask

  task automatic test_cr_lf_bs;
    goto_cell(5, 3);
    drive_model(8'h0D);
    n_cmp++; if (obs_we || obs_col != 0 || obs_row != 3) begin n_fail++; $display("[TB] FAIL cr: got we=%0d (%0d,%0d) expected 0 (0,3)", obs_we, obs_col, obs_row); end
    drive_model(8'h0A);
    n_cmp++; if (obs_we || obs_col != 0 || obs_row != 4) begin n_fail++; $display("[TB] FAIL lf: got we=%0d (%0d,%0d) expected 0 (0,4)", obs_we, obs_col, obs_row); end
    drive_model(8'h08);
    n_cmp++; if (obs_we || obs_col != 0 || obs_row != 4) begin n_fail++; $display("[TB] FAIL bs_col0: got we=%0d (%0d,%0d) expected 0 (0,4)", obs_we, obs_col, obs_row); end
  endtask

  task automatic test_bs;
    goto_cell(5, 3);
    drive_model(8'h08);
    n_cmp++; if (!obs_we || obs_addr != 244 || obs_din != 8'h20) begin n_fail++; $display("[TB] FAIL bs_write: got we=%0d addr=%0d din=%0h expected 1/244/20", obs_we, obs_addr, obs_din); end
    n_cmp++; if (obs_col != 4 || obs_row != 3) begin n_fail++; $display("[TB] FAIL bs_cursor: got (%0d,%0d) expected (4,3)", obs_col, obs_row); end
  endtask

  task automatic test_random;
    logic [7:0] b;
    int sel;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        n_cmp++; if (write_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_idle[%0d]: got we=%0d expected 0", i, write_en); end
        continue;
      end
      sel = $urandom_range(0, 9);
      if (sel < 6)       b = 8'($urandom_range(32, 126));
      else if (sel == 6) b = 8'h0D;
      else if (sel == 7) b = 8'h0A;
      else if (sel == 8) b = 8'h08;
      else begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h0C) b = 8'h01;
      end
      drive_model(b);
      n_cmp++; if (!obs_ready) begin n_fail++; $display("[TB] FAIL rnd_ready[%0d]: got 0 expected 1", i); end
      n_cmp++; if (obs_we != exp_we) begin n_fail++; $display("[TB] FAIL rnd_we[%0d] byte %0h: got %0d expected %0d", i, b, obs_we, exp_we); end
      if (exp_we) begin
        n_cmp++; if (obs_addr != exp_addr || obs_din != exp_din) begin n_fail++; $display("[TB] FAIL rnd_data[%0d]: got %0d/%0h expected %0d/%0h", i, obs_addr, obs_din, exp_addr, exp_din); end
      end
      n_cmp++; if (obs_col != m_col || obs_row != m_row) begin n_fail++; $display("[TB] FAIL rnd_cursor[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, obs_col, obs_row, m_col, m_row); end
    end
  endtask

  task automatic test_clear_cmd;
    int n; bit aok, bok;
    goto_cell(7, 2);
    cmd_clear = 1'b1; in_valid = 1'b1; in_data = 8'h41;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL cmd_ready: got %0d expected 0", in_ready); end
    @(posedge clk); #1;
    cmd_clear = 1'b0; in_valid = 1'b0;
    n_cmp++; if (write_en !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL cmd_enter: got we=%0d busy=%0d expected 0/1", write_en, busy); end
    cmd_clear = 1'b1;
    drain_clear(1000, n, aok, bok);
    cmd_clear = 1'b0;
    n_cmp++; if (n != 1000 || !aok || !bok) begin n_fail++; $display("[TB] FAIL cmd_partial: got n=%0d ok=%0d/%0d expected 1000 1/1", n, aok, bok); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (write_en !== 1'b0 || busy !== 1'b1 || cursor_col !== 7'd0 || cursor_row !== 6'd0) begin n_fail++; $display("[TB] FAIL midclear_rst: got we=%0d busy=%0d (%0d,%0d) expected 0/1 (0,0)", write_en, busy, cursor_col, cursor_row); end
    rst = 1'b0;
    drain_clear(0, n, aok, bok);
    n_cmp++; if (n != CELLS || !aok || !bok) begin n_fail++; $display("[TB] FAIL restart_clear: got n=%0d ok=%0d/%0d expected %0d 1/1", n, aok, bok, CELLS); end
    m_col = 0; m_row = 0;
  endtask

  task automatic test_ff;
    int n; bit aok, bok;
    goto_cell(12, 9);
    send_byte(8'h0C);
    n_cmp++; if (obs_we || !busy) begin n_fail++; $display("[TB] FAIL ff_enter: got we=%0d busy=%0d expected 0/1", obs_we, busy); end
    drain_clear(0, n, aok, bok);
    n_cmp++; if (n != CELLS || !aok) begin n_fail++; $display("[TB] FAIL ff_clear: got n=%0d ok=%0d expected %0d 1", n, aok, CELLS); end
    n_cmp++; if (cursor_col !== 7'd0 || cursor_row !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ff_home: got (%0d,%0d) busy=%0d expected (0,0) 0", cursor_col, cursor_row, busy); end
    m_col = 0; m_row = 0;
  endtask

  task automatic test_reset_midstream;
    int n; bit aok, bok;
    goto_cell(5, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (cursor_col !== 7'd0 || cursor_row !== 6'd0 || busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_rst: got (%0d,%0d) busy=%0d ready=%0d expected (0,0) 1 0", cursor_col, cursor_row, busy, in_ready); end
    rst = 1'b0;
    drain_clear(0, n, aok, bok);
    n_cmp++; if (n != CELLS || !aok) begin n_fail++; $display("[TB] FAIL stream_rst_clear: got n=%0d ok=%0d expected %0d 1", n, aok, CELLS); end
    m_col = 0; m_row = 0;
  endtask

  initial begin
    test_reset;
    test_ab;
    test_wrap;
    test_cr_lf_bs;
    test_bs;
    test_random;
    test_clear_cmd;
    test_ff;
    test_reset_midstream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
